// File: rtl/cadr_spc_pkg.sv
// Shared constants and operation encodings for the CADR subroutine PC stack.
// Opcodes are the 2-bit value {spush, spop}.
package cadr_spc_pkg;

  localparam int SPC_WIDTH = 19;
  localparam int SPC_DEPTH = 32;
  localparam int PTR_W     = 5;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } spc_op_e;

  function automatic spc_op_e decode_op(input logic spush, input logic spop);
    return spc_op_e'({spush, spop});
  endfunction

endpackage

// File: rtl/spc_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// No reset; contents survive a stack reset.
module spc_ram #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spc_stack.sv
// Subroutine PC stack: push/pop/replace on state_fetch, registered top-of-stack.
// Optional depth tracking with sticky overflow/underflow flags under SPC_STACK_CHECK_EN.
module spc_stack #(
  parameter int SPC_WIDTH = cadr_spc_pkg::SPC_WIDTH,
  parameter int SPC_DEPTH = cadr_spc_pkg::SPC_DEPTH,
  parameter int PTR_W     = cadr_spc_pkg::PTR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 state_fetch,
  input  logic                 spush,
  input  logic                 spop,
  input  logic [SPC_WIDTH-1:0] spcw,
  output logic [SPC_WIDTH-1:0] spc,
  output logic [PTR_W-1:0]     spcptr,
  output logic                 spcovf,
  output logic                 spcunf
);

  import cadr_spc_pkg::*;

  // state_fetch is a one-cycle strobe with no back-pressure: every edge where
  // it is high commits exactly one operation selected by {spush, spop}.
  spc_op_e              op;
  logic [PTR_W-1:0]     ptr_inc;
  logic [PTR_W-1:0]     ptr_dec;
  logic                 ram_we;
  logic [PTR_W-1:0]     ram_waddr;
  logic [SPC_WIDTH-1:0] ram_rdata;

  assign op        = decode_op(spush, spop);
  assign ptr_inc   = spcptr + PTR_W'(1);
  assign ptr_dec   = spcptr - PTR_W'(1);
  assign ram_we    = state_fetch && !reset && (op == PUSH || op == REPLACE);
  assign ram_waddr = (op == PUSH) ? ptr_inc : spcptr;

  spc_ram #(
    .WIDTH (SPC_WIDTH),
    .DEPTH (SPC_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (spcw),
    .raddr (ptr_dec),
    .rdata (ram_rdata)
  );

  // spc takes write data directly so it tracks mem[spcptr] without a RAW bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      spcptr <= '0;
      spc    <= '0;
    end else if (state_fetch) begin
      case (op)
        PUSH: begin
          spcptr <= ptr_inc;
          spc    <= spcw;
        end
        POP: begin
          spcptr <= ptr_dec;
          spc    <= ram_rdata;
        end
        REPLACE: spc <= spcw;
        HOLD:    ;
      endcase
    end
  end

`ifdef SPC_STACK_CHECK_EN
  localparam int DEPTH_W = PTR_W + 1;

  logic [DEPTH_W-1:0] depth;

  // Depth saturates at both ends; the pointer keeps wrapping regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth  <= '0;
      spcovf <= 1'b0;
      spcunf <= 1'b0;
    end else if (state_fetch) begin
      if (op == PUSH) begin
        if (depth == DEPTH_W'(SPC_DEPTH)) spcovf <= 1'b1;
        else                              depth  <= depth + DEPTH_W'(1);
      end else if (op == POP) begin
        if (depth == '0) spcunf <= 1'b1;
        else             depth  <= depth - DEPTH_W'(1);
      end
    end
  end
`else
  assign spcovf = 1'b0;
  assign spcunf = 1'b0;
`endif

endmodule

// File: tb/tb_spc_stack.sv
// Self-checking bench for spc_stack: reference model feeds an expected queue,
// each scenario task pops and compares after every clock edge.
module tb_spc_stack;

  localparam int W = 19;
  localparam int P = 5;
  localparam int EW = 2 + P + W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         state_fetch = 1'b0;
  logic         spush = 1'b0;
  logic         spop = 1'b0;
  logic [W-1:0] spcw = '0;
  logic [W-1:0] spc;
  logic [P-1:0] spcptr;
  logic         spcovf;
  logic         spcunf;

  spc_stack dut (
    .clk         (clk),
    .reset       (reset),
    .state_fetch (state_fetch),
    .spush       (spush),
    .spop        (spop),
    .spcw        (spcw),
    .spc         (spc),
    .spcptr      (spcptr),
    .spcovf      (spcovf),
    .spcunf      (spcunf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] got_v;

  logic [W-1:0] m_mem [32];
  logic [P-1:0] m_ptr = '0;
  logic [W-1:0] m_spc = '0;
  int           m_depth = 0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  // Drive one cycle, update the model, queue the expected post-edge state.
  task automatic drive(input logic r, input logic f, input logic p, input logic q,
                       input logic [W-1:0] d);
    @(negedge clk);
    reset = r; state_fetch = f; spush = p; spop = q; spcw = d;
    if (r) begin
      m_ptr = '0; m_spc = '0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (f) begin
      case ({p, q})
        2'b10: begin
          m_ptr = m_ptr + 5'd1; m_mem[m_ptr] = d; m_spc = d;
`ifdef SPC_STACK_CHECK_EN
          if (m_depth == 32) m_ovf = 1'b1; else m_depth++;
`endif
        end
        2'b01: begin
          m_ptr = m_ptr - 5'd1; m_spc = m_mem[m_ptr];
`ifdef SPC_STACK_CHECK_EN
          if (m_depth == 0) m_unf = 1'b1; else m_depth--;
`endif
        end
        2'b11: begin m_mem[m_ptr] = d; m_spc = d; end
        default: ;
      endcase
    end
    exp_q.push_back({m_ovf, m_unf, m_ptr, m_spc});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 19'h12345);
    exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc};
    checks++;
    if (got_v !== exp_v) begin
      failures++; $display("FAIL reset_sb got=%h exp=%h", got_v, exp_v);
    end
    checks++;
    if ({spcovf, spcunf, spcptr, spc} !== '0) begin
      failures++; $display("FAIL reset_zero got=%h exp=0", {spcovf, spcunf, spcptr, spc});
    end
  endtask

  task automatic test_push_pop;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b1, 1'b0, 19'h00123);
    exp_v = exp_q.pop_front(); checks++;
    if ({spcovf, spcunf, spcptr, spc} !== exp_v || spcptr !== 5'd1 || spc !== 19'h00123) begin
      failures++; $display("FAIL first_push got ptr=%0d spc=%h exp ptr=1 spc=00123", spcptr, spc);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, W'(i * 16));
      exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc}; checks++;
      if (got_v !== exp_v) begin
        failures++; $display("FAIL push_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
      exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc}; checks++;
      if (got_v !== exp_v || spcptr !== P'(2 - i) || spc !== W'(32 - 16 * i)) begin
        failures++; $display("FAIL pop_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_replace;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, W'(i * 16));
      void'(exp_q.pop_front());
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 19'h7ABCD);
    exp_v = exp_q.pop_front(); checks++;
    if ({spcovf, spcunf, spcptr, spc} !== exp_v || spcptr !== 5'd3 || spc !== 19'h7ABCD) begin
      failures++; $display("FAIL replace got ptr=%0d spc=%h exp ptr=3 spc=7abcd", spcptr, spc);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
      exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc}; checks++;
      if (got_v !== exp_v || spc !== W'(32 - 16 * i)) begin
        failures++; $display("FAIL replace_pop_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_no_fetch;
    logic [P-1:0] ptr0;
    logic [W-1:0] spc0;
    ptr0 = m_ptr; spc0 = m_spc;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 19'h7FFFF)));
      exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc}; checks++;
      if (got_v !== exp_v || spcptr !== ptr0 || spc !== spc0) begin
        failures++; $display("FAIL no_fetch_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_overflow;
    logic exp_ovf;
`ifdef SPC_STACK_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 33; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, W'(i));
      exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc}; checks++;
      if (got_v !== exp_v) begin
        failures++; $display("FAIL ovf_push_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
    checks++;
    if (spcptr !== 5'd1 || spc !== 19'd33 || spcovf !== exp_ovf || spcunf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_final got ptr=%0d spc=%0d ovf=%b exp ptr=1 spc=33 ovf=%b",
               spcptr, spc, spcovf, exp_ovf);
    end
    // Popping back to entry 0 exposes the wrapped overwrite.
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    exp_v = exp_q.pop_front(); checks++;
    if ({spcovf, spcunf, spcptr, spc} !== exp_v || spcptr !== 5'd0 || spc !== 19'd32) begin
      failures++; $display("FAIL ovf_entry0 got ptr=%0d spc=%0d exp ptr=0 spc=32", spcptr, spc);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), W'($urandom_range(0, 19'h7FFFF)));
      exp_v = exp_q.pop_front(); got_v = {spcovf, spcunf, spcptr, spc}; checks++;
      if (got_v !== exp_v) begin
        failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_underflow;
    logic exp_unf;
`ifdef SPC_STACK_CHECK_EN
    exp_unf = 1'b1;
`else
    exp_unf = 1'b0;
`endif
    // Fill every entry with a known value so the wrapped pop reads defined data.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 32; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, W'(i + 100));
      void'(exp_q.pop_front());
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    exp_v = exp_q.pop_front(); checks++;
    if ({spcovf, spcunf, spcptr, spc} !== exp_v || spcptr !== 5'd31 || spc !== 19'd131
        || spcunf !== exp_unf || spcovf !== 1'b0) begin
      failures++;
      $display("FAIL unf_pop got ptr=%0d spc=%0d unf=%b exp ptr=31 spc=131 unf=%b",
               spcptr, spc, spcunf, exp_unf);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_v = exp_q.pop_front(); checks++;
    if ({spcovf, spcunf, spcptr, spc} !== exp_v || {spcovf, spcunf, spcptr, spc} !== '0) begin
      failures++; $display("FAIL unf_reset got=%h exp=0", {spcovf, spcunf, spcptr, spc});
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_replace();
    test_no_fetch();
    test_overflow();
    test_back_to_back();
    test_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spc_stack.md
# spc_stack

Subroutine PC stack for the CADR micro-sequencer: the writer/holder side of the `spc` return-address path that the next-PC selector consumes. The stack holds 32 entries of 19 bits and is updated once per microinstruction on `state_fetch`. It pushes a return word, pops to return, or replaces the top entry. It presents the current top entry as `spc` for the PC mux to select on a return (`pcs = 00`).

## Interface
Parameters:
- `SPC_WIDTH`, 19: width of a stack entry; bits [13:0] are a micro-PC, and bits [18:14] are flag/return bits carried opaquely.
- `SPC_DEPTH`, 32: number of entries; must be a power of two.
- `PTR_W`, 5: pointer width, log2(`SPC_DEPTH`).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `state_fetch`  in  1  update strobe; the stack changes only on edges where this is 1.
- `spush`  in  1  push request, qualified by `state_fetch`.
- `spop`  in  1  pop request, qualified by `state_fetch`.
- `spcw`  in  SPC_WIDTH  word to push or to replace the top with.
- `spc`  out  SPC_WIDTH  registered copy of the current top entry.
- `spcptr`  out  PTR_W  current stack pointer; it indexes the top entry.
- `spcovf`  out  1  sticky overflow flag; present only with `SPC_STACK_CHECK_EN`.
- `spcunf`  out  1  sticky underflow flag; present only with `SPC_STACK_CHECK_EN`.

## Operation
- Reset sets `spcptr` to 0, `spc` to 0, `spcovf` to 0, `spcunf` to 0 and the depth counter to 0. The RAM contents are not reset.
- Nothing changes on an edge where `state_fetch` is 0, whatever the values of `spush` and `spop`.
- With `state_fetch` = 1, the request bits select one of four operations:
  - `spush` = 1, `spop` = 0 (push): `spcptr` becomes `spcptr`+1, `mem[spcptr+1]` is written with `spcw`, and `spc` becomes `spcw`.
  - `spush` = 0, `spop` = 1 (pop): `spcptr` becomes `spcptr`-1, and `spc` becomes `mem[spcptr-1]`, i.e. the entry below the old top.
  - `spush` = 1, `spop` = 1 (replace): `spcptr` is unchanged, `mem[spcptr]` is written with `spcw`, and `spc` becomes `spcw`.
  - `spush` = 0, `spop` = 0 (hold): nothing changes.
- Pointer arithmetic is modulo `SPC_DEPTH`:
  - A push at pointer 31 wraps to 0 and silently overwrites entry 0.
  - A pop at pointer 0 wraps to 31; `spc` then holds `mem[31]` as it stands.
- The `spc` register always equals `mem[spcptr]` once the RAM entry at `spcptr` has been written, including right after a write to that address (same-edge bypass).
- `spcw` is stored verbatim; no bits are modified.

## Timing
- All operations complete in a single cycle.
- New `spc` and `spcptr` values are visible in the cycle after the `state_fetch` edge, in time for the next `npc` selection.
- The RAM is written on the same edge; `spc` takes the write data directly, so there is no read-after-write hazard.
- Back-to-back operations on consecutive `state_fetch` edges are fully supported.
- `reset` has priority over `state_fetch`: reset asserted together with a push leaves the pointer at 0 and does not update `spc`.

## Configuration
- Macro: `SPC_STACK_CHECK_EN`.
- When defined, the block adds a 6-bit depth counter (range 0..32) that tracks pushes and pops; replace and hold leave it unchanged.
  - A push at depth 32 sets `spcovf`; the depth stays at 32.
  - A pop at depth 0 sets `spcunf`; the depth stays at 0.
  - The pointer and data still wrap exactly as described under Operation.
  - Both flags are sticky and clear only on reset.
- When not defined, there is no depth counter, and `spcovf` and `spcunf` are driven constant 0.

## Structure
- Shared package `cadr_spc_pkg` holds:
  - constants `SPC_WIDTH`, `SPC_DEPTH`, `PTR_W`;
  - the opcode encodings PUSH, POP, REPLACE, HOLD, as the 2-bit value {`spush`,`spop`}.
- Sub-module `spc_ram`: a 32x19 RAM with one synchronous write port and one asynchronous read port (read address `spcptr`-1, for pops). It has no reset.
- The top level contains the pointer, the `spc` register, the operation decode and the optional check logic.

## Test plan
- Reset, then push 19'h00123 with `state_fetch` = 1 -> next cycle `spcptr` = 1 and `spc` = 19'h00123.
- Push 19'h00010, 19'h00020, 19'h00030, then pop twice -> `spc` reads 19'h00020 then 19'h00010, and `spcptr` reads 2 then 1.
- With `spcptr` = 3 and `spc` = 19'h00030, drive `spush` = `spop` = 1 with `spcw` = 19'h7ABCD -> `spcptr` stays 3 and `spc` = 19'h7ABCD; a following pop then push-free pop returns the entries at pointers 2 and 1 unchanged.
- Drive `spush` = 1 with `state_fetch` = 0 for 5 cycles -> `spcptr` and `spc` stay unchanged.
- From reset, do 33 pushes of values 1..33 -> `spcptr` = 1 and `spc` = 33, entry 0 holds 32, and with the macro `spcovf` = 1 on the 33rd push.
- From reset, pop once -> `spcptr` = 31, and with the macro `spcunf` = 1; assert reset in the next cycle -> `spcptr` = 0, `spc` = 0 and both flags = 0.
